// File: rtl/linebuffer_writer.sv
// rtl/linebuffer_writer.sv - writes each visible capture pixel once into a circular multi-line RAM buffer
// Optional frame counter: define LINEBUFFER_FRAME_COUNTER_EN.
module linebuffer_writer #(
  parameter int WIDTH         = 720,
  parameter int HEIGHT        = 480,
  parameter int WIDTH_LD      = 640,
  parameter int HEIGHT_LD     = 480,
  parameter int LINES         = 4,
  parameter int TRIGGER_LINES = 2,
  parameter int ADDR_W        = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        red,
  input  logic [7:0]        green,
  input  logic [7:0]        blue,
  input  logic [11:0]       counterX,
  input  logic [11:0]       counterY,
  input  logic              line_doubler,
  input  logic              resync,
  output logic [ADDR_W-1:0] ram_wraddr,
  output logic [23:0]       ram_wrdata,
  output logic              ram_wren,
  output logic              starttrigger,
  output logic [7:0]        frame_count
);

  typedef enum logic [1:0] {SYNC_WAIT, FILL, RUN} state_t;

  localparam int LD_W = $clog2(TRIGGER_LINES + 1);
  localparam logic [11:0]     W_N     = 12'(WIDTH);
  localparam logic [11:0]     H_N     = 12'(HEIGHT);
  localparam logic [11:0]     W_LD    = 12'(WIDTH_LD);
  localparam logic [11:0]     H_LD    = 12'(HEIGHT_LD);
  localparam logic [ADDR_W:0] SPAN_N  = (ADDR_W+1)'(LINES * WIDTH);
  localparam logic [ADDR_W:0] SPAN_LD = (ADDR_W+1)'(LINES * WIDTH_LD);
  localparam logic [LD_W-1:0] TRIG    = LD_W'(TRIGGER_LINES);

  state_t            state, state_next;
  logic [11:0]       x_prev;
  logic              ld_prev;
  logic [ADDR_W-1:0] slot_base;
  logic [LD_W-1:0]   lines_done, lines_next;

  logic [11:0]       w_act, h_act;
  logic [ADDR_W:0]   span;
  logic              pixel_event, at_origin, line_end, abort, wr_en;
  logic [ADDR_W-1:0] base, wr_addr, slot_next;
  logic [ADDR_W:0]   base_plus_w;

  assign w_act = line_doubler ? W_LD : W_N;
  assign h_act = line_doubler ? H_LD : H_N;
  assign span  = line_doubler ? SPAN_LD : SPAN_N;

  // counterX is held for two clocks; only its change marks a new pixel
  assign pixel_event = (counterX != x_prev) && (counterX < w_act) && (counterY < h_act);
  assign at_origin   = pixel_event && (counterX == 12'd0) && (counterY == 12'd0);
  assign line_end    = pixel_event && (counterX == w_act - 12'd1);
  assign abort       = resync || (line_doubler != ld_prev);
  assign wr_en       = !abort && ((state == SYNC_WAIT) ? at_origin : pixel_event);

  // a frame origin always lands in slot 0, realigning the ring
  assign base        = at_origin ? '0 : slot_base;
  assign wr_addr     = base + ADDR_W'(counterX);
  assign base_plus_w = {1'b0, base} + (ADDR_W+1)'(w_act);
  assign slot_next   = (base_plus_w >= span) ? '0 : base_plus_w[ADDR_W-1:0];

  always_comb begin
    lines_next = lines_done;
    if (wr_en) begin
      lines_next = (state == SYNC_WAIT) ? '0 : lines_done;
      if (line_end && (lines_next < TRIG))
        lines_next = lines_next + LD_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_prev     <= 12'hFFF;
      ld_prev    <= 1'b0;
      slot_base  <= '0;
      lines_done <= '0;
      ram_wren   <= 1'b0;
      ram_wraddr <= '0;
      ram_wrdata <= '0;
    end else begin
      x_prev     <= counterX;
      ld_prev    <= line_doubler;
      lines_done <= lines_next;
      ram_wren   <= wr_en;
      if (wr_en) begin
        ram_wraddr <= wr_addr;
        ram_wrdata <= {red, green, blue};
        slot_base  <= line_end ? slot_next : base;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= SYNC_WAIT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      SYNC_WAIT: if (wr_en) state_next = FILL;
      FILL:      if (wr_en && (lines_next == TRIG)) state_next = RUN;
      RUN:       state_next = RUN;
      default:   state_next = SYNC_WAIT;
    endcase
    if (abort) state_next = SYNC_WAIT;
  end

  always_comb begin
    starttrigger = (state == RUN);
  end

`ifdef LINEBUFFER_FRAME_COUNTER_EN
  logic [7:0] frame_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      frame_q <= 8'd0;
    else if (wr_en && at_origin && (state != SYNC_WAIT))
      frame_q <= frame_q + 8'd1;
  end

  assign frame_count = frame_q;
`else
  assign frame_count = 8'd0;
`endif

endmodule

// File: tb/tb_linebuffer_writer.sv
// tb/tb_linebuffer_writer.sv - directed self-checking bench for linebuffer_writer
module tb_linebuffer_writer;

  logic        clock, reset;
  logic [7:0]  red, green, blue;
  logic [11:0] counterX, counterY;
  logic        line_doubler, resync;
  logic [11:0] ram_wraddr;
  logic [23:0] ram_wrdata;
  logic        ram_wren, starttrigger;
  logic [7:0]  frame_count;

  int checks = 0;
  int errors = 0;

  int          pix_n;
  logic [11:0] pix_addr;
  logic [23:0] pix_data;
  logic        pix_trig;

  logic [11:0] ln_first, ln_last;
  int          ln_pulses, ln_bad;
  logic        ln_trig_pre, ln_trig;
  int          acc;
  logic [31:0] fc_exp;

  linebuffer_writer dut (
    .clock(clock), .reset(reset),
    .red(red), .green(green), .blue(blue),
    .counterX(counterX), .counterY(counterY),
    .line_doubler(line_doubler), .resync(resync),
    .ram_wraddr(ram_wraddr), .ram_wrdata(ram_wrdata), .ram_wren(ram_wren),
    .starttrigger(starttrigger), .frame_count(frame_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // present one pixel for two clocks; capture what the event cycle produced
  task automatic pix(input int x, input int y);
    logic [7:0] xb, yb;
    xb = 8'(x);
    yb = 8'(y);
    counterX = 12'(x);
    counterY = 12'(y);
    red = xb; green = yb; blue = xb ^ yb;
    @(posedge clock); #1;
    pix_n    = ram_wren ? 1 : 0;
    pix_addr = ram_wraddr;
    pix_data = ram_wrdata;
    pix_trig = starttrigger;
    @(posedge clock); #1;
    if (ram_wren) pix_n++;
  endtask

  task automatic line(input int y, input int w);
    logic [7:0] xb, yb;
    ln_pulses = 0;
    ln_bad = 0;
    for (int x = 0; x < w; x++) begin
      pix(x, y);
      ln_pulses += pix_n;
      xb = 8'(x);
      yb = 8'(y);
      if (pix_n != 0 && pix_data !== {xb, yb, xb ^ yb}) ln_bad++;
      if (x == 0) ln_first = pix_addr;
      if (x == w - 2) ln_trig_pre = pix_trig;
      if (x == w - 1) begin
        ln_last = pix_addr;
        ln_trig = pix_trig;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef LINEBUFFER_FRAME_COUNTER_EN
    fc_exp = 32'd2;
`else
    fc_exp = 32'd0;
`endif
    reset = 1'b1; resync = 1'b0; line_doubler = 1'b0;
    counterX = 12'd720; counterY = 12'd480;
    red = 8'd0; green = 8'd0; blue = 8'd0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_wren",  32'(ram_wren), 32'd0);
    check("rst_addr",  32'(ram_wraddr), 32'd0);
    check("rst_data",  32'(ram_wrdata), 32'd0);
    check("rst_trig",  32'(starttrigger), 32'd0);
    check("rst_frame", 32'(frame_count), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("idle_no_write", 32'(ram_wren), 32'd0);

    // priming frame, normal geometry
    line(0, 720);
    check("l0_first",  32'(ln_first), 32'd0);
    check("l0_last",   32'(ln_last), 32'd719);
    check("l0_pulses", 32'(ln_pulses), 32'd720);
    check("l0_data",   32'(ln_bad), 32'd0);
    check("l0_trig",   32'(ln_trig), 32'd0);
    line(1, 720);
    check("l1_trig_pre", 32'(ln_trig_pre), 32'd0);
    check("l1_trig_rise", 32'(ln_trig), 32'd1);
    check("l1_last",   32'(ln_last), 32'd1439);
    line(2, 720);
    check("l2_first",  32'(ln_first), 32'd1440);
    line(3, 720);
    check("l3_last",   32'(ln_last), 32'd2879);
    line(4, 720);
    check("l4_wrap",   32'(ln_first), 32'd0);
    check("l4_pulses", 32'(ln_pulses), 32'd720);
    pix(720, 5);
    check("x720_no_write", 32'(pix_n), 32'd0);

    // resync mid-line
    acc = 0;
    for (int x = 0; x < 100; x++) begin
      pix(x, 5);
      if (x == 0) check("l5_first", 32'(pix_addr), 32'd720);
      acc += pix_n;
    end
    check("l5_pre_pulses", 32'(acc), 32'd100);
    resync = 1'b1;
    pix(100, 5);
    check("resync_no_write", 32'(pix_n), 32'd0);
    check("resync_trig_low", 32'(pix_trig), 32'd0);
    resync = 1'b0;
    acc = 0;
    for (int x = 101; x < 720; x++) begin
      pix(x, 5);
      acc += pix_n;
    end
    check("sync_wait_no_write", 32'(acc), 32'd0);
    line(0, 720);
    check("resume_first",  32'(ln_first), 32'd0);
    check("resume_pulses", 32'(ln_pulses), 32'd720);
    check("resume_trig",   32'(ln_trig), 32'd0);
    line(1, 720);
    check("reprime_trig",  32'(ln_trig), 32'd1);

    // frame realignment while running
    line(0, 720);
    check("realign_first", 32'(ln_first), 32'd0);
    line(1, 720);
    check("realign_l1", 32'(ln_first), 32'd720);
    line(0, 720);
    check("frame_count", 32'(frame_count), fc_exp);

    // resync coinciding with the frame origin
    resync = 1'b1;
    pix(0, 0);
    check("origin_resync_no_write", 32'(pix_n), 32'd0);
    check("origin_resync_trig", 32'(pix_trig), 32'd0);
    resync = 1'b0;
    pix(1, 0);
    check("sync_wait_x1", 32'(pix_n), 32'd0);
    line(0, 720);
    check("recover_first", 32'(ln_first), 32'd0);
    check("recover_trig",  32'(ln_trig), 32'd0);
    line(1, 720);
    check("recover_run",   32'(ln_trig), 32'd1);

    // switch to line-doubler geometry while running
    line_doubler = 1'b1;
    pix(5, 2);
    check("mode_no_write", 32'(pix_n), 32'd0);
    check("mode_trig",     32'(pix_trig), 32'd0);
    line(0, 640);
    check("ld_l0_first",  32'(ln_first), 32'd0);
    check("ld_l0_last",   32'(ln_last), 32'd639);
    check("ld_l0_pulses", 32'(ln_pulses), 32'd640);
    pix(640, 1);
    check("ld_x640_no_write", 32'(pix_n), 32'd0);
    line(1, 640);
    check("ld_l1_first", 32'(ln_first), 32'd640);
    check("ld_trig",     32'(ln_trig), 32'd1);
    check("frame_count_hold", 32'(frame_count), fc_exp);

    // asynchronous reset while a write strobe is up
    counterX = 12'd5; counterY = 12'd1;
    @(posedge clock); #1;
    check("pre_reset_wren", 32'(ram_wren), 32'd1);
    reset = 1'b1;
    #1;
    check("async_reset_wren", 32'(ram_wren), 32'd0);
    check("async_reset_trig", 32'(starttrigger), 32'd0);
    check("async_reset_addr", 32'(ram_wraddr), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/linebuffer_writer.md
# linebuffer_writer

Downstream of the capture/decode stage: takes the per-pixel RGB stream with its visible-area counters and writes each visible pixel once into a circular multi-line RAM buffer. The HDMI output side reads that buffer. The block handles frame alignment and the resync request. It also raises `starttrigger` once enough lines are buffered for the output side to start reading safely. Everything runs in the capture clock domain; the RAM read port is out of scope.

## Interface
Parameters:
- `WIDTH`, 720: visible pixels per line, normal mode
- `HEIGHT`, 480: visible lines, normal mode
- `WIDTH_LD`, 640: visible pixels per line, line-doubler mode
- `HEIGHT_LD`, 480: visible lines, line-doubler mode
- `LINES`, 4: number of line slots in the RAM
- `TRIGGER_LINES`, 2: lines that must be completed after frame alignment before `starttrigger` rises
- `ADDR_W`, 12: RAM address width; must satisfy LINES*max(WIDTH,WIDTH_LD) ≤ 2^ADDR_W

Ports:
- `clock`  in  1  capture clock
- `reset`  in  1  asynchronous, active-high
- `red`, `green`, `blue`  in  8 each  pixel data, valid in the same cycle as the counters
- `counterX`  in  12  visible-area X; holds for 2 clocks per pixel
- `counterY`  in  12  visible-area Y
- `line_doubler`  in  1  selects the `_LD` geometry
- `resync`  in  1  high = output side must realign
- `ram_wraddr`  out  ADDR_W  write address
- `ram_wrdata`  out  24  {red, green, blue}
- `ram_wren`  out  1  one-cycle write strobe
- `starttrigger`  out  1  buffer primed, output side may read
- `frame_count`  out  8  completed-frame counter (see Configuration)

## Operation
Geometry:
- Active width W and height H are (WIDTH_LD, HEIGHT_LD) when `line_doubler`=1, else (WIDTH, HEIGHT).

Pixel detection:
- Register `x_prev` holds the previous cycle's `counterX`; it resets to 12'hFFF.
- A pixel event occurs in a cycle when `counterX` ≠ `x_prev`, `counterX` < W and `counterY` < H.
- Each pixel is therefore written exactly once, even though its value is presented for 2 clocks.

Addressing:
- `slot_base` register: ADDR_W bits, reset 0.
- Address is `slot_base + counterX`; this is an adder, not a multiplier.
- On a pixel event with `counterX` = W−1: `slot_base` += W, wrapping to 0 when the result would equal LINES*W.
- `lines_done` (saturating at TRIGGER_LINES) increments at the same point.

State machine (reset state SYNC_WAIT):
- SYNC_WAIT
  - Writes are suppressed, except that a pixel event at (0,0) while `resync`=0 is written with `slot_base`=0.
  - On that event: `lines_done`=0, go to FILL.
- FILL
  - All pixel events are written.
  - When `lines_done` reaches TRIGGER_LINES, go to RUN.
- RUN
  - `starttrigger`=1.
  - Writing continues as in FILL.
- Frame realignment (FILL or RUN):
  - A pixel event at (0,0) forces `slot_base` to 0 for that write.
  - The following line starts at W.
- From any state, go to SYNC_WAIT with `starttrigger`=0 in the next cycle when either occurs:
  - `resync`=1;
  - `line_doubler` differs from its value in the previous cycle.
- In that same cycle the pixel event is not written.

Simultaneous events:
- `resync`=1 together with a (0,0) event: resync wins and nothing is written.
- A pixel event with x=W−1 while leaving FILL: the write occurs and the state becomes RUN.

## Timing
- Write latency is 1 clock. Inputs are sampled in pixel-event cycle N; `ram_wren`, `ram_wraddr` and `ram_wrdata` are valid in N+1.
- `ram_wren` is high for exactly 1 cycle per event.
- `starttrigger` rises in the cycle after the write of the TRIGGER_LINES-th completed line.
- `starttrigger` falls 1 cycle after `resync` is sampled high.
- Reset values: `ram_wraddr`=0, `ram_wrdata`=0, `ram_wren`=0, `starttrigger`=0, `frame_count`=0, state=SYNC_WAIT, `slot_base`=0, `lines_done`=0.
- Asserting `reset` mid-write aborts the write immediately, because reset is asynchronous.

## Configuration
- `LINEBUFFER_FRAME_COUNTER_EN`
  - Defined: `frame_count` increments (8-bit, wraps 255→0) on each (0,0) pixel event written while in FILL or RUN, i.e. on each realigned frame.
  - Undefined: `frame_count` is tied to 0 and no counter logic is synthesized.

## Test plan
- **Reset/priming:** Defaults, normal mode. Release reset with `resync`=0 and feed a frame starting at (0,0) → first write has addr 0; `starttrigger` rises 1 clk after the write of (719,1); the write of (0,2) has addr 1440.
- **Slot wrap:** Stream 5 lines → line 4 writes at addr 0 again; the last write of line 3 has addr 2879.
- **Once-per-pixel:** Hold each counterX for 2 clks → exactly 720 `ram_wren` pulses per line. Present x=720 → no write.
- **Resync mid-frame:** Pulse `resync` at (100,3) → `starttrigger` low 1 clk later; no writes until the next (0,0) event; writing resumes at addr 0.
- **Mode change:** Toggle `line_doubler` to 1 while in RUN → SYNC_WAIT. The next frame uses W=640, so line 1 starts at addr 640.
- **Frame counter:** With `LINEBUFFER_FRAME_COUNTER_EN` defined, run 3 frames after priming → `frame_count`=2. Without the macro → `frame_count`=0 throughout.
